// File: rtl/adder.sv
// AXI4-Lite slave exposing a 32-bit adder: two RW operand registers,
// combinational SUM and carry STATUS, one outstanding transaction per channel.
module adder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic                    s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic                    s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        REG_OP_A   = 2'd0,
        REG_OP_B   = 2'd1,
        REG_SUM    = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH:0]   sum_full;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  wr_err;
    logic                  wr_sel_a;
    logic                  wr_sel_b;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_data;

    // The spare strobe bit carries no meaning.
    logic unused_wstrb;
    assign unused_wstrb = s1_axi_wstrb[STRB_W];

    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

    assign s1_axi_awready = wr_accept;
    assign s1_axi_wready  = wr_accept;
    assign s1_axi_arready = rd_accept;

    assign wr_hs = s1_axi_awvalid & wr_accept & s1_axi_wvalid;
    assign rd_hs = s1_axi_arvalid & rd_accept;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        wr_sel_a = 1'b0;
        wr_sel_b = 1'b0;
        wr_err   = 1'b1;
        if (s1_axi_awaddr[1:0] == 2'b00 && s1_axi_awaddr[ADDR_WIDTH-1:4] == '0) begin
            case (reg_sel_e'(s1_axi_awaddr[3:2]))
                REG_OP_A: begin wr_sel_a = 1'b1; wr_err = 1'b0; end
                REG_OP_B: begin wr_sel_b = 1'b1; wr_err = 1'b0; end
                default:  wr_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (s1_axi_araddr[1:0] == 2'b00 && s1_axi_araddr[ADDR_WIDTH-1:4] == '0) begin
            rd_err = 1'b0;
            case (reg_sel_e'(s1_axi_araddr[3:2]))
                REG_OP_A: rd_data = op_a;
                REG_OP_B: rd_data = op_b;
                REG_SUM:  rd_data = sum_full[DATA_WIDTH-1:0];
                default:  rd_data = {{(DATA_WIDTH-1){1'b0}}, sum_full[DATA_WIDTH]};
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; a same-edge read therefore sees pre-write data.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            op_a          <= '0;
            op_b          <= '0;
            wr_accept     <= 1'b0;
            s1_axi_bvalid <= 1'b0;
            s1_axi_bresp  <= 1'b0;
        end else begin
            wr_accept <= s1_axi_awvalid & s1_axi_wvalid & ~wr_accept & ~s1_axi_bvalid;
            if (wr_hs) begin
                s1_axi_bvalid <= 1'b1;
                s1_axi_bresp  <= wr_err;
                if (wr_sel_a) op_a <= merge_bytes(op_a, s1_axi_wdata, s1_axi_wstrb[STRB_W-1:0]);
                if (wr_sel_b) op_b <= merge_bytes(op_b, s1_axi_wdata, s1_axi_wstrb[STRB_W-1:0]);
            end else if (s1_axi_bvalid && s1_axi_bready) begin
                s1_axi_bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured at the AR handshake and held until R completes.
    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            rd_accept     <= 1'b0;
            s1_axi_rvalid <= 1'b0;
            s1_axi_rresp  <= 1'b0;
            s1_axi_rdata  <= '0;
        end else begin
            rd_accept <= s1_axi_arvalid & ~rd_accept & ~s1_axi_rvalid;
            if (rd_hs) begin
                s1_axi_rvalid <= 1'b1;
                s1_axi_rresp  <= rd_err;
                s1_axi_rdata  <= rd_data;
            end else if (s1_axi_rvalid && s1_axi_rready) begin
                s1_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the AXI4-Lite adder: directed register-map cases,
// back-pressure, concurrency and reset, plus randomized traffic against a model.
module tb_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [4:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_a;
    logic [31:0] m_b;

    always #5 clk = ~clk;

    adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .s1_axi_aclk    (clk),
        .s1_axi_aresetn (rst_n),
        .s1_axi_awaddr  (awaddr),
        .s1_axi_awvalid (awvalid),
        .s1_axi_awready (awready),
        .s1_axi_wdata   (wdata),
        .s1_axi_wstrb   (wstrb),
        .s1_axi_wvalid  (wvalid),
        .s1_axi_wready  (wready),
        .s1_axi_bresp   (bresp),
        .s1_axi_bvalid  (bvalid),
        .s1_axi_bready  (bready),
        .s1_axi_araddr  (araddr),
        .s1_axi_arvalid (arvalid),
        .s1_axi_arready (arready),
        .s1_axi_rdata   (rdata),
        .s1_axi_rresp   (rresp),
        .s1_axi_rvalid  (rvalid),
        .s1_axi_rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: register file semantics with plain integer arithmetic.
    function automatic void model_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        logic [32:0] s;
        s = {1'b0, m_a} + {1'b0, m_b};
        d = 32'h0;
        e = 1'b0;
        if (a % 4 != 0 || a >= 16) e = 1'b1;
        else if (a == 0)           d = m_a;
        else if (a == 4)           d = m_b;
        else if (a == 8)           d = s[31:0];
        else                       d = {31'b0, s[32]};
    endfunction

    function automatic logic model_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] t;
        if (a % 4 != 0 || a >= 16 || a == 8 || a == 12) return 1'b1;
        t = (a == 0) ? m_a : m_b;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) t[8*i +: 8] = d[8*i +: 8];
        end
        if (a == 0) m_a = t;
        else        m_b = t;
        return 1'b0;
    endfunction

    task automatic wait_aw_accept();
        int n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_w_accept", {31'b0, awready && wready}, 32'd1);
    endtask

    task automatic wait_ar_accept();
        int n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ar_accept", {31'b0, arready}, 32'd1);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                             output logic resp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_aw_accept();
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_set", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        araddr = a; arvalid = 1'b1;
        wait_ar_accept();
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid_set", {31'b0, rvalid}, 32'd1);
        d = rdata;
        e = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", {31'b0, rvalid}, 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
        logic exp_e;
        logic got_e;
        exp_e = model_write(a, d, s);
        axi_write(a, d, s, got_e);
        check("bresp", {31'b0, got_e}, {31'b0, exp_e});
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [31:0] exp_d;
        logic        exp_e;
        logic [31:0] got_d;
        logic        got_e;
        model_read(a, exp_d, exp_e);
        axi_read(a, got_d, got_e);
        check("rdata", got_d, exp_d);
        check("rresp", {31'b0, got_e}, {31'b0, exp_e});
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_d;
        logic        exp_e;
        logic [31:0] old_sum;

        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        m_a = '0; m_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {25'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sum and carry.
        do_write(8'h00, 32'd39, 5'h0F);
        do_write(8'h04, 32'd40, 5'h0F);
        axi_read(8'h08, d, e);
        check("sum_39_40", d, 32'd79);
        check("sum_39_40_resp", {31'b0, e}, 32'd0);
        do_read(8'h0C);
        do_write(8'h00, 32'hFFFF_FFFF, 5'h0F);
        do_write(8'h04, 32'd2, 5'h0F);
        axi_read(8'h08, d, e);
        check("sum_wrap", d, 32'h0000_0001);
        axi_read(8'h0C, d, e);
        check("carry_out", d, 32'h0000_0001);

        // Error addresses leave state untouched.
        do_write(8'h23, 32'd76, 5'h0F);
        do_write(8'h2D, 32'd76, 5'h0F);
        do_read(8'h00);
        do_read(8'h04);
        axi_read(8'h23, d, e);
        check("rd_err_data", d, 32'd0);
        check("rd_err_resp", {31'b0, e}, 32'd1);

        // Byte strobes, and writes to read-only registers.
        do_write(8'h00, 32'd0, 5'h0F);
        do_write(8'h00, 32'h1234_5678, 5'h01);
        axi_read(8'h00, d, e);
        check("strb_byte0", d, 32'h0000_0078);
        do_write(8'h00, 32'hAABB_CCDD, 5'h10);
        do_read(8'h00);
        do_write(8'h08, 32'hDEAD_BEEF, 5'h0F);
        do_write(8'h0C, 32'hDEAD_BEEF, 5'h0F);
        do_read(8'h08);

        // Write back-pressure: second request must not be accepted.
        void'(model_write(8'h04, 32'h0000_0100, 5'h0F));
        awaddr = 8'h04; wdata = 32'h0000_0100; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
        wait_aw_accept();
        @(posedge clk); #1;
        awaddr = 8'h00; wdata = 32'h0000_0005; wstrb = 5'h0F;
        repeat (3) begin
            @(negedge clk);
            check("hold_bvalid", {31'b0, bvalid}, 32'd1);
            check("hold_awready", {31'b0, awready}, 32'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        do_write(8'h00, 32'h0000_0005, 5'h0F);

        // Read back-pressure: rdata stays stable while rready is low.
        model_read(8'h08, exp_d, exp_e);
        araddr = 8'h08; arvalid = 1'b1;
        wait_ar_accept();
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_rvalid", {31'b0, rvalid}, 32'd1);
            check("hold_rdata", rdata, exp_d);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;

        // Read and write completing on the same edge: read sees old sum.
        model_read(8'h08, old_sum, exp_e);
        araddr = 8'h08; arvalid = 1'b1;
        awaddr = 8'h00; wdata = 32'h0000_1000; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
        wait_aw_accept();
        check("same_edge_arready", {31'b0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        void'(model_write(8'h00, 32'h0000_1000, 5'h0F));
        check("same_edge_rdata", rdata, old_sum);
        check("same_edge_bvalid", {31'b0, bvalid}, 32'd1);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        do_read(8'h08);

        // Randomized traffic, including misaligned and out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            do_write(8'($urandom_range(0, 19)), $urandom, 5'($urandom_range(0, 31)));
            do_read(8'($urandom_range(0, 19)));
            do_read(8'h08);
            do_read(8'h0C);
        end

        // Reset in the middle of outstanding traffic.
        araddr = 8'h08; arvalid = 1'b1;
        wait_ar_accept();
        @(posedge clk); #1;
        arvalid = 1'b0;
        awaddr = 8'h00; wdata = 32'h5555_5555; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
        wait_aw_accept();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {25'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        m_a = '0; m_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(8'h08, d, e);
        check("post_reset_sum", d, 32'd0);
        do_read(8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- AXI4-Lite memory-mapped slave wrapping a 32-bit adder.
- Software writes two operands and reads back their sum and carry-out.
- Sits on the control/peripheral interconnect as a simple register-mapped compute block with one clock domain.

Parameters:
- DATA_WIDTH, 32, data bus and operand/result width (fixed at 32 in this revision).
- ADDR_WIDTH, 8, byte-address width of AW/AR channels.

Ports:
- s1_axi_aclk  in  1  clock; all logic on rising edge.
- s1_axi_aresetn  in  1  reset, asynchronous, active-low.
- s1_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s1_axi_awvalid  in  1  write address valid.
- s1_axi_awready  out  1  write address ready.
- s1_axi_wdata  in  DATA_WIDTH  write data.
- s1_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bits [DATA_WIDTH/8-1:0] used, top bit ignored.
- s1_axi_wvalid  in  1  write data valid.
- s1_axi_wready  out  1  write data ready.
- s1_axi_bresp  out  1  write response; 0=OKAY, 1=error.
- s1_axi_bvalid  out  1  write response valid.
- s1_axi_bready  in  1  write response ready.
- s1_axi_araddr  in  ADDR_WIDTH  read byte address.
- s1_axi_arvalid  in  1  read address valid.
- s1_axi_arready  out  1  read address ready.
- s1_axi_rdata  out  DATA_WIDTH  read data.
- s1_axi_rresp  out  1  read response; 0=OKAY, 1=error.
- s1_axi_rvalid  out  1  read data valid.
- s1_axi_rready  in  1  read data ready.

Behaviour:
- Reset (aresetn=0, async): every output 0; OP_A, OP_B = 0; takes effect immediately, aborting any in-flight transaction (no response issued).
- Register map (byte address, word aligned):
  - 0x00 OP_A, RW.
  - 0x04 OP_B, RW.
  - 0x08 SUM, RO; (OP_A+OP_B) mod 2^32.
  - 0x0C STATUS, RO; bit0 = carry-out of OP_A+OP_B, bits[31:1]=0.
- SUM and STATUS are combinational from OP_A/OP_B, so a read issued after a write's B handshake returns the updated result.
- Write channel:
  - When awvalid & wvalid & !awready & !bvalid, assert awready and wready together for exactly one cycle.
  - On the edge where both handshakes complete: perform write, set bvalid=1, drive bresp.
  - bvalid holds until the edge where bready=1, then clears.
  - AW without W, or W without AW, is not accepted; wait.
- Write effect:
  - Byte i of the target register updates only if wstrb[i]=1.
  - wstrb=0 leaves the register unchanged but still gives OKAY.
- Write errors (bresp=1, no state change):
  - address with awaddr[1:0]!=0;
  - address >= 0x10;
  - write to 0x08 or 0x0C.
- Read channel:
  - When arvalid & !arready & !rvalid, assert arready for one cycle.
  - On the handshake edge: latch rdata from the decoded register, set rvalid=1, drive rresp.
  - rdata/rresp hold stable while rvalid=1; rvalid clears on the edge where rready=1.
- Read errors (rresp=1, rdata=0): unaligned address or address >= 0x10.
- Concurrency: read and write channels are independent; both may complete in the same cycle. A read completing on the same edge as a write returns pre-write register contents.
- One outstanding transaction per channel; no new accept until its response handshake completes.
- Arithmetic: unsigned; carry is bit 32 of the 33-bit sum.

Test Plan:
- Write 0x00=39, 0x04=40 (wstrb=0xF) -> each bresp=0; read 0x08 -> rdata=79, rresp=0; read 0x0C -> 0.
- Write 0x00=0xFFFFFFFF, 0x04=2 -> read 0x08 = 0x00000001; read 0x0C = 0x00000001.
- Write 0x23 (35) or 0x2D (45) with data 76 -> bresp=1; OP_A/OP_B unchanged; read 0x23 -> rresp=1, rdata=0.
- OP_A=0, then write 0x00=0x12345678 with wstrb=0x1 -> read 0x00 = 0x00000078; write 0x08 -> bresp=1, SUM unchanged.
- Hold bready=0 after a write -> bvalid stays 1 and awready stays 0 for a second request; hold rready=0 -> rvalid/rdata stable.
- Assert aresetn=0 mid-transaction -> all outputs 0 immediately; after release, read 0x08 -> 0.
